tiny_dnn_layer_seq: RTL and testbench

Layer sequencer for the tiny-dnn accelerator top. It holds a small descriptor table of up to N_LAYER layers and steps through them. Each layer gets a weight-load phase, a bias-load phase, and an execute phase, driving the top's mode strobes (wwrite, bwrite, run, pool, backprop, deltaw, enbias, last). Phases advance by counting src/dst stream handshakes, which the sequencer observes but never drives.

---
 rtl/tiny_dnn_layer_seq.sv | 211 +++++++++++++++++++++
 tb/tb_tiny_dnn_layer_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_layer_seq.sv
// Layer sequencer for the tiny-dnn accelerator: walks a small descriptor table and
// drives the top's weight-load / bias-load / execute mode strobes per layer.
module tiny_dnn_layer_seq #(
    parameter int N_LAYER = 8,
    parameter int CW      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [$clog2(N_LAYER)-1:0]   cfg_addr,
    input  logic [1:0]                   cfg_mode,
    input  logic                         cfg_enbias,
    input  logic [CW-1:0]                cfg_wbeats,
    input  logic [CW-1:0]                cfg_bbeats,
    input  logic                         start,
    input  logic                         abort,
    input  logic [$clog2(N_LAYER):0]     nlayer,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [$clog2(N_LAYER)-1:0]   layer_idx,
    output logic                         wwrite,
    output logic                         bwrite,
    output logic                         run,
    output logic                         pool,
    output logic                         backprop,
    output logic                         deltaw,
    output logic                         enbias,
    output logic                         last,
    input  logic                         src_valid,
    input  logic                         src_ready,
    input  logic                         dst_valid,
    input  logic                         dst_ready,
    input  logic                         dst_last
);

    localparam int AW = $clog2(N_LAYER);
    localparam logic [AW:0] NL_MAX = (AW+1)'(N_LAYER);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_BLOAD, S_EXEC, S_GAP, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        M_FWD, M_POOL, M_BP, M_DW
    } mode_t;

    logic [1:0]    t_mode   [N_LAYER];
    logic          t_enbias [N_LAYER];
    logic [CW-1:0] t_wbeats [N_LAYER];
    logic [CW-1:0] t_bbeats [N_LAYER];

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   nl_q, nl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cfg_err_q;

    logic          src_hs, dst_end, last_layer;
    logic [AW-1:0] e_idx;
    logic          e_pool;
    state_t        e_state;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    md;
    logic          busy_d, done_d, wwrite_d, bwrite_d, run_d, pool_d;
    logic          backprop_d, deltaw_d, enbias_d, last_d;

    // Descriptor table has no reset; writes are only taken while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            t_mode[cfg_addr]   <= cfg_mode;
            t_enbias[cfg_addr] <= cfg_enbias;
            t_wbeats[cfg_addr] <= cfg_wbeats;
            t_bbeats[cfg_addr] <= cfg_bbeats;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            nl_q      <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wwrite    <= 1'b0;
            bwrite    <= 1'b0;
            run       <= 1'b0;
            pool      <= 1'b0;
            backprop  <= 1'b0;
            deltaw    <= 1'b0;
            enbias    <= 1'b0;
            last      <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nl_q     <= nl_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            wwrite   <= wwrite_d;
            bwrite   <= bwrite_d;
            run      <= run_d;
            pool     <= pool_d;
            backprop <= backprop_d;
            deltaw   <= deltaw_d;
            enbias   <= enbias_d;
            last     <= last_d;
            if (state_q == S_IDLE && start && !abort)
                cfg_err_q <= 1'b0;
            else if (cfg_we && busy)
                cfg_err_q <= 1'b1;
        end
    end

    assign cfg_err   = cfg_err_q;
    assign layer_idx = idx_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nl_d    = nl_q;
        cnt_d   = cnt_q;

        src_hs     = src_valid && src_ready;
        dst_end    = dst_valid && dst_ready && dst_last;
        last_layer = (({1'b0, idx_q} + (AW+1)'(1)) == nl_q);
        cnt_inc    = cnt_q + CW'(1);

        // Entry phase of the next layer: layer 0 from IDLE, otherwise idx+1 from GAP.
        e_idx   = (state_q == S_IDLE) ? '0 : idx_q + AW'(1);
        e_pool  = (t_mode[e_idx] == M_POOL);
        if (!e_pool && t_wbeats[e_idx] != '0)
            e_state = S_WLOAD;
        else if (!e_pool && t_bbeats[e_idx] != '0)
            e_state = S_BLOAD;
        else
            e_state = S_EXEC;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (nlayer == '0) begin
                        nl_d    = '0;
                        state_d = S_FIN;
                    end else begin
                        nl_d    = (nlayer > NL_MAX) ? NL_MAX : nlayer;
                        idx_d   = '0;
                        state_d = e_state;
                    end
                end
            end
            S_WLOAD: begin
                if (src_hs) begin
                    if (cnt_inc == t_wbeats[idx_q]) begin
                        cnt_d   = '0;
                        state_d = (t_bbeats[idx_q] != '0) ? S_BLOAD : S_EXEC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_BLOAD: begin
                if (src_hs) begin
                    if (cnt_inc == t_bbeats[idx_q]) begin
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_EXEC: begin
                if (dst_end)
                    state_d = S_GAP;
            end
            S_GAP: begin
                if (last_layer) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = e_idx;
                    state_d = e_state;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state so the registered strobes track state_q.
        md         = t_mode[idx_d];
        busy_d     = (state_d == S_WLOAD) || (state_d == S_BLOAD) ||
                     (state_d == S_EXEC)  || (state_d == S_GAP);
        done_d     = (state_d == S_FIN);
        wwrite_d   = (state_d == S_WLOAD);
        bwrite_d   = (state_d == S_BLOAD);
        run_d      = (state_d == S_EXEC) && (md != M_POOL);
        pool_d     = (state_d == S_EXEC) && (md == M_POOL);
        backprop_d = (state_d == S_EXEC) && (md == M_BP);
        deltaw_d   = (state_d == S_EXEC) && (md == M_DW);
        enbias_d   = (state_d == S_EXEC) && (md == M_FWD) && t_enbias[idx_d];
        last_d     = (state_d == S_EXEC) &&
                     (({1'b0, idx_d} + (AW+1)'(1)) == nl_d);
    end

endmodule

// File: tb/tb_tiny_dnn_layer_seq.sv
// Scoreboard bench for tiny_dnn_layer_seq: per-cycle expected output vectors are queued
// when a sequence is started and compared on each falling edge.
module tb_tiny_dnn_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [1:0]  cfg_mode;
    logic        cfg_enbias;
    logic [15:0] cfg_wbeats;
    logic [15:0] cfg_bbeats;
    logic        start;
    logic        abort;
    logic [3:0]  nlayer;
    logic        busy, done, cfg_err;
    logic [2:0]  layer_idx;
    logic        wwrite, bwrite, run, pool, backprop, deltaw, enbias, last;
    logic        src_valid, src_ready, dst_valid, dst_ready, dst_last;

    int n_tests = 0;
    int n_fail  = 0;
    logic [13:0] exp_q[$];

    tiny_dnn_layer_seq #(.N_LAYER(8), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
        .cfg_enbias(cfg_enbias), .cfg_wbeats(cfg_wbeats), .cfg_bbeats(cfg_bbeats),
        .start(start), .abort(abort), .nlayer(nlayer),
        .busy(busy), .done(done), .cfg_err(cfg_err), .layer_idx(layer_idx),
        .wwrite(wwrite), .bwrite(bwrite), .run(run), .pool(pool),
        .backprop(backprop), .deltaw(deltaw), .enbias(enbias), .last(last),
        .src_valid(src_valid), .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // {cfg_err, busy, done, wwrite, bwrite, run, pool, backprop, deltaw, enbias, last, idx[2:0]}
    function automatic logic [13:0] obs();
        return {cfg_err, busy, done, wwrite, bwrite, run, pool, backprop, deltaw,
                enbias, last, layer_idx};
    endfunction

    function automatic logic [13:0] f_w(input logic [2:0] i);
        logic [13:0] v = '0;
        v[12] = 1'b1; v[10] = 1'b1; v[2:0] = i;
        return v;
    endfunction

    function automatic logic [13:0] f_b(input logic [2:0] i);
        logic [13:0] v = '0;
        v[12] = 1'b1; v[9] = 1'b1; v[2:0] = i;
        return v;
    endfunction

    function automatic logic [13:0] f_ex(input logic pl, input logic bp, input logic dw,
                                         input logic eb, input logic ls, input logic [2:0] i);
        logic [13:0] v = '0;
        v[12] = 1'b1; v[8] = !pl; v[7] = pl; v[6] = bp; v[5] = dw;
        v[4] = eb; v[3] = ls; v[2:0] = i;
        return v;
    endfunction

    function automatic logic [13:0] f_gap(input logic [2:0] i);
        logic [13:0] v = '0;
        v[12] = 1'b1; v[2:0] = i;
        return v;
    endfunction

    function automatic logic [13:0] f_fin();
        logic [13:0] v = '0;
        v[11] = 1'b1;
        return v;
    endfunction

    task automatic push(input int n, input logic [13:0] v, input logic err);
        for (int i = 0; i < n; i++) exp_q.push_back({err, v[12:0]});
    endtask

    // layer_idx is only meaningful while busy
    always @(negedge clk) begin
        logic [13:0] e, o;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs();
            if (!e[12]) begin
                e[2:0] = '0;
                o[2:0] = '0;
            end
            check("seq", {18'd0, o}, {18'd0, e});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic eb,
                      input logic [15:0] wb, input logic [15:0] bb);
        cfg_we = 1'b1; cfg_addr = a; cfg_mode = m; cfg_enbias = eb;
        cfg_wbeats = wb; cfg_bbeats = bb;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] nl);
        start = 1'b1; nlayer = nl;
        tick();
        start = 1'b0;
    endtask

    task automatic dst_pulse();
        dst_valid = 1'b1; dst_ready = 1'b1; dst_last = 1'b1;
        tick();
        dst_valid = 1'b0; dst_ready = 1'b0; dst_last = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        #1;
    endtask

    initial begin
        int dn;
        logic [5:0] pat;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; cfg_enbias = 1'b0;
        cfg_wbeats = '0; cfg_bbeats = '0; start = 1'b0; abort = 1'b0; nlayer = '0;
        src_valid = 1'b0; src_ready = 1'b0; dst_valid = 1'b0; dst_ready = 1'b0;
        dst_last = 1'b0;
        #12;
        check("reset", {18'd0, obs()}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single forward layer: 4 weight beats, 1 bias beat, continuous source
        wr(3'd0, 2'd0, 1'b1, 16'd4, 16'd1);
        src_valid = 1'b1; src_ready = 1'b1;
        go(4'd1);
        push(4, f_w(3'd0), 1'b0);
        push(1, f_b(3'd0), 1'b0);
        push(3, f_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0), 1'b0);
        push(1, f_gap(3'd0), 1'b0);
        push(1, f_fin(), 1'b0);
        push(1, '0, 1'b0);
        repeat (7) tick();
        dst_pulse();
        drain();

        // pool layer (weights ignored) followed by a forward layer
        wr(3'd0, 2'd1, 1'b1, 16'd3, 16'd2);
        wr(3'd1, 2'd0, 1'b0, 16'd2, 16'd0);
        go(4'd2);
        push(1, f_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0);
        push(1, f_gap(3'd0), 1'b0);
        push(2, f_w(3'd1), 1'b0);
        push(2, f_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1), 1'b0);
        push(1, f_gap(3'd1), 1'b0);
        push(1, f_fin(), 1'b0);
        push(1, '0, 1'b0);
        dst_pulse();
        repeat (4) tick();
        dst_pulse();
        drain();

        // weight load under source backpressure
        wr(3'd0, 2'd0, 1'b0, 16'd3, 16'd0);
        src_ready = 1'b0;
        go(4'd1);
        push(6, f_w(3'd0), 1'b0);
        push(1, f_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0), 1'b0);
        push(1, f_gap(3'd0), 1'b0);
        push(1, f_fin(), 1'b0);
        push(1, '0, 1'b0);
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            src_ready = pat[i];
            tick();
        end
        src_ready = 1'b0;
        dst_pulse();
        drain();

        // backprop / deltaw decode and abort in EXEC of layer 1 of 3, then restart
        wr(3'd0, 2'd2, 1'b1, 16'd0, 16'd0);
        wr(3'd1, 2'd3, 1'b1, 16'd0, 16'd0);
        wr(3'd2, 2'd0, 1'b0, 16'd0, 16'd0);
        go(4'd3);
        push(1, f_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0);
        push(1, f_gap(3'd0), 1'b0);
        push(1, f_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), 1'b0);
        push(2, '0, 1'b0);
        dst_pulse();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        drain();
        go(4'd1);
        push(1, f_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0), 1'b0);
        push(1, f_gap(3'd0), 1'b0);
        push(1, f_fin(), 1'b0);
        push(1, '0, 1'b0);
        dst_pulse();
        drain();

        // descriptor write while busy is dropped and flags cfg_err
        wr(3'd0, 2'd0, 1'b1, 16'd4, 16'd0);
        src_valid = 1'b1; src_ready = 1'b0;
        go(4'd1);
        push(1, f_w(3'd0), 1'b0);
        push(4, f_w(3'd0), 1'b1);
        push(2, f_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0), 1'b1);
        push(1, f_gap(3'd0), 1'b1);
        push(1, f_fin(), 1'b1);
        push(1, '0, 1'b1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_mode = 2'd1; cfg_enbias = 1'b0;
        cfg_wbeats = 16'd0; cfg_bbeats = 16'd0;
        tick();
        cfg_we = 1'b0; src_ready = 1'b1;
        repeat (5) tick();
        dst_pulse();
        src_valid = 1'b0; src_ready = 1'b0;
        drain();

        // nlayer 0: a single done pulse, no strobes, cfg_err cleared by start
        go(4'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += int'(done);
            check("nl0_quiet", {23'd0, busy, wwrite, bwrite, run, pool, backprop,
                                deltaw, enbias, last}, 32'd0);
        end
        check("nl0_done", dn, 1);
        check("nl0_err", {31'd0, cfg_err}, 32'd0);
        tick();

        // asynchronous reset in the middle of a bias load
        wr(3'd0, 2'd0, 1'b0, 16'd1, 16'd4);
        src_valid = 1'b1; src_ready = 1'b1;
        go(4'd1);
        push(1, f_w(3'd0), 1'b0);
        push(1, f_b(3'd0), 1'b0);
        tick();
        tick();
        check("pre_rst_bwrite", {31'd0, bwrite}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", {18'd0, obs()}, 32'd0);
        check("async_rst_q", exp_q.size(), 0);
        src_valid = 1'b0; src_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
